// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
//   Round-robin scanner for an I2C ADC front end. For each channel it
//   oversamples 2^AVG_LOG2 conversions through a req/ack handshake, averages
//   them, scales the average to millivolts, converts the result to packed BCD
//   with a bit-serial double-dabble, and stores it in that channel's slice
//   of bcd_out.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   enable     1 = scan continuously, 0 = stop after the current channel
//   conv_req   conversion request, held until conv_ack
//   conv_ch    channel address for the request
//   conv_ack   conversion complete, conv_data valid in the same cycle
//   conv_data  raw sample
//   bcd_out    packed BCD, channel k at [k*DIGITS*4 +: DIGITS*4]
//   upd_valid  one-cycle pulse when a channel word is written
//   upd_ch     channel written, valid with upd_valid
//   scan_done  one-cycle pulse when the last channel is written
//   overrange  sticky flag, set when a scaled value had to be clamped
module adc_scan_sequencer #(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2,
    parameter int VREF_MV  = 3300,
    parameter int DIGITS   = 4,
    parameter int CH_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic                     conv_req,
    output logic [CH_W-1:0]          conv_ch,
    input  logic                     conv_ack,
    input  logic [DATA_W-1:0]        conv_data,
    output logic [N_CH*DIGITS*4-1:0] bcd_out,
    output logic                     upd_valid,
    output logic [CH_W-1:0]          upd_ch,
    output logic                     scan_done,
    output logic                     overrange
);

    localparam int BCD_W  = DIGITS * 4;
    localparam int MAX_MV = 10 ** DIGITS - 1;
    localparam int BIN_W  = $clog2(MAX_MV + 1);   // double-dabble iterations
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int PROD_W = DATA_W + 32;           // room for avg * VREF_MV
    localparam int BITC_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] N_SAMP = CNT_W'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ACC, S_SCALE, S_BCD, S_STORE
    } state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ptr_q, ptr_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIN_W-1:0]          bin_q, bin_d;
    logic [BCD_W-1:0]          bcd_q, bcd_d;
    logic [BITC_W-1:0]         bitc_q, bitc_d;
    logic [N_CH*BCD_W-1:0]     bcd_out_q, bcd_out_d;
    logic                      upd_valid_q, upd_valid_d;
    logic [CH_W-1:0]           upd_ch_q, upd_ch_d;
    logic                      scan_done_q, scan_done_d;
    logic                      overrange_q, overrange_d;

    // Scaling datapath: only consumed in SCALE.
    logic [PROD_W-1:0] avg_ext, prod, mv;
    logic              clamp;
    logic [BIN_W-1:0]  mv_bin;

    always_comb begin
        avg_ext = PROD_W'(acc_q >> AVG_LOG2);
        prod    = avg_ext * PROD_W'(VREF_MV);
        mv      = prod >> DATA_W;
        clamp   = (mv > PROD_W'(MAX_MV));
        mv_bin  = clamp ? BIN_W'(MAX_MV) : mv[BIN_W-1:0];
    end

    // Add-3 correction on every BCD digit that is 5 or more, applied before
    // each left shift of the double-dabble.
    logic [BCD_W-1:0] bcd_adj;
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 :
                                        bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        bitc_d      = bitc_q;
        bcd_out_d   = bcd_out_q;
        upd_valid_d = 1'b0;
        upd_ch_d    = upd_ch_q;
        scan_done_d = 1'b0;
        overrange_d = overrange_q;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_REQ;
            end
            S_REQ: begin
                if (conv_ack) begin
                    acc_d   = acc_q + ACC_W'(conv_data);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                state_d = (cnt_q < N_SAMP) ? S_REQ : S_SCALE;
            end
            S_SCALE: begin
                bin_d  = mv_bin;
                bcd_d  = '0;
                bitc_d = '0;
                if (clamp) overrange_d = 1'b1;
                state_d = S_BCD;
            end
            S_BCD: begin
                bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d  = bin_q << 1;
                bitc_d = bitc_q + 1'b1;
                if (bitc_q == BITC_W'(BIN_W - 1)) state_d = S_STORE;
            end
            S_STORE: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (ptr_q == CH_W'(k)) bcd_out_d[k*BCD_W +: BCD_W] = bcd_q;
                end
                upd_valid_d = 1'b1;
                upd_ch_d    = ptr_q;
                if (ptr_q == CH_W'(N_CH - 1)) begin
                    scan_done_d = 1'b1;
                    ptr_d       = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
                acc_d   = '0;
                cnt_d   = '0;
                state_d = enable ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            bitc_q      <= '0;
            bcd_out_q   <= '0;
            upd_valid_q <= 1'b0;
            upd_ch_q    <= '0;
            scan_done_q <= 1'b0;
            overrange_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            bitc_q      <= bitc_d;
            bcd_out_q   <= bcd_out_d;
            upd_valid_q <= upd_valid_d;
            upd_ch_q    <= upd_ch_d;
            scan_done_q <= scan_done_d;
            overrange_q <= overrange_d;
        end
    end

    // conv_req is decoded from the state so it drops with the async reset.
    assign conv_req  = (state_q == S_REQ);
    assign conv_ch   = ptr_q;
    assign bcd_out   = bcd_out_q;
    assign upd_valid = upd_valid_q;
    assign upd_ch    = upd_ch_q;
    assign scan_done = scan_done_q;
    assign overrange = overrange_q;

endmodule
